instr_encoder: RTL and testbench



---
 rtl/rv_isa_pkg.sv | 24 ++
 rtl/instr_pack.sv | 48 ++++
 rtl/instr_encoder.sv | 71 +++++++
 tb/tb_instr_encoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// RV32I opcode and field constants shared by the decoder and encoder.
package rv_isa_pkg;

    localparam int XLEN    = 32;
    localparam int OP_W    = 7;
    localparam int F3_W    = 3;
    localparam int F7_W    = 7;
    localparam int REG_W   = 5;
    localparam int RFLD_W  = 7;

    localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    // Register fields are wider than the ISA index; upper bits must be clear.
    function automatic logic reg_bad(input logic [RFLD_W-1:0] r);
        return |r[RFLD_W-1:REG_W];
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded RV32I fields to a 32-bit word plus error flag.
module instr_pack
    import rv_isa_pkg::*;
(
    input  logic [OP_W-1:0]   opcode,
    input  logic [F3_W-1:0]   funct3,
    input  logic [F7_W-1:0]   funct7,
    input  logic [RFLD_W-1:0] rs1,
    input  logic [RFLD_W-1:0] rs2,
    input  logic [RFLD_W-1:0] rd,
    input  logic [XLEN-1:0]   imm,
    output logic [XLEN-1:0]   instr,
    output logic              err
);

    logic imm12_ok;
    logic [XLEN-1:0] word;

    // Immediate must be a sign extension of its low 12 bits.
    assign imm12_ok = (&imm[31:11]) || !(|imm[31:11]);

    always_comb begin
        word = '0;
        err  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                word = {funct7, rs2[4:0], rs1[4:0], funct3, rd[4:0], opcode};
                err  = reg_bad(rs1) || reg_bad(rs2) || reg_bad(rd);
            end
            OP_ITYPE, OP_LOAD: begin
                word = {imm[11:0], rs1[4:0], funct3, rd[4:0], opcode};
                err  = reg_bad(rs1) || reg_bad(rd) || !imm12_ok;
            end
            OP_STORE: begin
                word = {imm[11:5], rs2[4:0], rs1[4:0], funct3,
                        imm[4:0], opcode};
                err  = reg_bad(rs1) || reg_bad(rs2) || !imm12_ok;
            end
            OP_LUI: begin
                word = {imm[31:12], rd[4:0], opcode};
                err  = reg_bad(rd) || (|imm[11:0]);
            end
            default: err = 1'b1;
        endcase
        instr = err ? '0 : word;
    end

endmodule

// File: rtl/instr_encoder.sv
// Registered RV32I encoder stage with address tagging and error counting.
module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   opcode,
    input  logic [F3_W-1:0]   funct3,
    input  logic [F7_W-1:0]   funct7,
    input  logic [RFLD_W-1:0] rs1,
    input  logic [RFLD_W-1:0] rs2,
    input  logic [RFLD_W-1:0] rd,
    input  logic [XLEN-1:0]   imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(4);

    logic [XLEN-1:0]   p_instr;
    logic              p_err;
    logic [ADDR_W-1:0] ptr;
    logic              accept;

    instr_pack u_pack (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd     (rd),
        .imm    (imm),
        .instr  (p_instr),
        .err    (p_err)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= START;
            out_err   <= 1'b0;
            err_count <= '0;
            ptr       <= START;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= p_instr;
            out_err   <= p_err;
            out_addr  <= ptr;
            ptr       <= ptr + STEP;
            if (p_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised and directed bench for instr_encoder against a field-level model.
module tb_instr_encoder;

    localparam int AW = 4;

    logic        clk = 0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [6:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [AW-1:0] out_addr;
    logic        out_err;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_valid;
    logic [31:0] m_instr;
    int          m_addr;
    bit          m_err;
    int          m_cnt;
    int          m_ptr;

    instr_encoder #(.ADDR_W(AW), .START_ADDR(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Encoding computed from field positions with plain arithmetic.
    function automatic void ref_encode(output logic [31:0] w,
                                       output bit e);
        longint unsigned acc;
        longint s;
        bit b1, b2, bd;
        b1 = rs1 > 31;
        b2 = rs2 > 31;
        bd = rd > 31;
        s = longint'($signed(imm));
        acc = 0;
        e = 0;
        if (opcode == 7'h33) begin
            e = b1 || b2 || bd;
            acc = funct7 * (2**25) + (rs2 % 32) * (2**20)
                + (rs1 % 32) * (2**15) + funct3 * (2**12)
                + (rd % 32) * (2**7) + opcode;
        end else if (opcode == 7'h13 || opcode == 7'h03) begin
            e = b1 || bd || s < -2048 || s > 2047;
            acc = (imm % 4096) * (2**20) + (rs1 % 32) * (2**15)
                + funct3 * (2**12) + (rd % 32) * (2**7) + opcode;
        end else if (opcode == 7'h23) begin
            e = b1 || b2 || s < -2048 || s > 2047;
            acc = ((imm / 32) % 128) * (2**25) + (rs2 % 32) * (2**20)
                + (rs1 % 32) * (2**15) + funct3 * (2**12)
                + (imm % 32) * (2**7) + opcode;
        end else if (opcode == 7'h37) begin
            e = bd || (imm % 4096) != 0;
            acc = (imm / 4096) * (2**12) + (rd % 32) * (2**7) + opcode;
        end else begin
            e = 1;
        end
        w = e ? 32'h0 : acc[31:0];
    endfunction

    task automatic set_b(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [6:0] a,
                         input logic [6:0] b, input logic [6:0] d,
                         input logic [31:0] im);
        opcode = op; funct3 = f3; funct7 = f7;
        rs1 = a; rs2 = b; rd = d; imm = im;
    endtask

    task automatic cycle();
        logic [31:0] w;
        bit e;
        @(negedge clk);
        check("in_ready", {31'b0, in_ready},
              {31'b0, (!m_valid || out_ready)});
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_instr = 0; m_addr = 0;
            m_err = 0; m_cnt = 0; m_ptr = 0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            ref_encode(w, e);
            m_valid = 1; m_instr = w; m_err = e;
            m_addr = m_ptr;
            m_ptr = (m_ptr + 4) % (1 << AW);
            if (e && m_cnt < 255) m_cnt++;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("out_instr", out_instr, m_instr);
        check("out_addr", {28'b0, out_addr}, m_addr);
        check("out_err", {31'b0, out_err}, {31'b0, m_err});
        check("err_count", {24'b0, err_count}, m_cnt);
    endtask

    task automatic rand_b();
        int k;
        logic [6:0] ops [5];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37};
        k = $urandom_range(0, 7);
        opcode = (k < 5) ? ops[k] : 7'($urandom);
        funct3 = 3'($urandom);
        funct7 = 7'($urandom);
        rs1 = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 31));
        rs2 = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 31));
        rd  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 31));
        k = $urandom_range(0, 3);
        if (k == 0) imm = $urandom;
        else if (k == 1) imm = $urandom & 32'hFFFF_F000;
        else imm = 32'($signed(12'($urandom)));
    endtask

    initial begin
        logic [31:0] held;
        rst = 1; in_valid = 0; out_ready = 1;
        set_b(7'h0, 0, 0, 0, 0, 0, 0);
        m_valid = 0; m_instr = 0; m_addr = 0;
        m_err = 0; m_cnt = 0; m_ptr = 0;
        cycle();
        rst = 0;
        cycle();

        // Directed words, back-to-back
        in_valid = 1;
        set_b(7'h33, 3'b000, 7'b0100000, 2, 3, 1, 0);
        cycle();
        check("r_word", out_instr, 32'h403100B3);
        set_b(7'h13, 3'b000, 0, 0, 0, 5, 32'hFFFFFFFF);
        cycle();
        check("addi_word", out_instr, 32'hFFF00293);
        set_b(7'h23, 3'b010, 0, 2, 8, 0, 32'hFFFFFFFC);
        cycle();
        check("sw_word", out_instr, 32'hFE812E23);
        check("sw_addr", {28'b0, out_addr}, 32'd8);
        set_b(7'h37, 0, 0, 0, 0, 1, 32'h12345000);
        cycle();
        check("lui_word", out_instr, 32'h123450B7);

        // Error bundles
        set_b(7'h13, 0, 0, 1, 0, 1, 32'h00000800);
        cycle();
        check("err_imm", {31'b0, out_err}, 32'd1);
        set_b(7'h37, 0, 0, 0, 0, 1, 32'h00000001);
        cycle();
        set_b(7'h7F, 0, 0, 0, 0, 0, 0);
        cycle();
        set_b(7'h33, 0, 0, 1, 1, 7'h20, 0);
        cycle();
        check("err_cnt4", {24'b0, err_count}, 32'd4);
        set_b(7'h13, 0, 7'h7F, 1, 7'h7F, 2, 32'h5);
        cycle();
        check("ign_fields", out_instr, 32'h00508113);

        // Backpressure
        out_ready = 0;
        set_b(7'h33, 0, 0, 4, 5, 6, 0);
        cycle();
        held = out_instr;
        set_b(7'h13, 0, 0, 7, 0, 8, 32'h10);
        for (int i = 0; i < 3; i++) cycle();
        check("bp_hold", out_instr, held);
        out_ready = 1;
        cycle();
        check("bp_next", out_instr, 32'h01038413);
        in_valid = 0;
        cycle();
        check("drain", {31'b0, out_valid}, 32'd0);

        // Saturation
        in_valid = 1;
        set_b(7'h7F, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) cycle();
        check("sat", {24'b0, err_count}, 32'd255);

        // Reset mid-transfer
        out_ready = 0;
        set_b(7'h33, 0, 0, 1, 1, 1, 0);
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        in_valid = 0;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_cnt", {24'b0, err_count}, 32'd0);
        out_ready = 1;
        cycle();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            rand_b();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
